// File: rtl/spi_pkg.sv
// Shared types and helpers for the configurable SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Width of the chip-select index; never narrower than one bit
  function automatic int unsigned cs_w(input int unsigned num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_master_cfg_if.sv
// Control/status and serial pins of the SPI master.
interface spi_master_cfg_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CS = 4,
  parameter int unsigned DIV_W  = 16
);
  localparam int unsigned CS_W = cs_w(NUM_CS);

  logic              start;
  logic              abort;
  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic [DIV_W-1:0]  div;
  logic [CS_W-1:0]   cs_sel;
  logic [DATA_W-1:0] tx;
  logic [DATA_W-1:0] rx;
  logic              busy;
  logic              done;
  logic              sck;
  logic              mosi;
  logic              miso;
  logic [NUM_CS-1:0] cs_n;

  // SPI master block view
  modport master (
    input  start, abort, cpol, cpha, lsb_first, div, cs_sel, tx, miso,
    output rx, busy, done, sck, mosi, cs_n
  );

  // Local controller plus attached SPI slave view
  modport slave (
    output start, abort, cpol, cpha, lsb_first, div, cs_sel, tx, miso,
    input  rx, busy, done, sck, mosi, cs_n
  );
endinterface

// File: rtl/spi_half_tick.sv
// SCK half-period timer: one-cycle tick every div+1 cycles while enabled.
module spi_half_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick_c
);
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;

  // Down-counter reloaded from the latched divider; counts to zero so div=max never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_div <= i_div;
      r_cnt <= i_div;
    end else if (i_en) begin
      r_cnt <= (r_cnt == '0) ? r_div : r_cnt - DIV_W'(1);
    end
  end

  assign o_tick_c = i_en && (r_cnt == '0);
endmodule

// File: rtl/spi_master_cfg.sv
// Mode-configurable SPI master: one full-duplex DATA_W-bit transfer per start.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CS = 4,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_cfg_if.master  bus
);
  localparam int unsigned CS_W  = cs_w(NUM_CS);
  localparam int unsigned EDGES = 2 * DATA_W;
  localparam int unsigned EC_W  = $clog2(EDGES + 1);

  spi_state_e        r_state;
  logic              r_cpol;
  logic              r_cpha;
  logic              r_lsb;
  logic [DATA_W-1:0] r_tx_sh;
  logic [DATA_W-1:0] r_rx_sh;
  logic [EC_W-1:0]   r_edge_cnt;
  logic              r_sck;
  logic              r_mosi;
  logic              r_busy;
  logic              r_done;
  logic [NUM_CS-1:0] r_cs_n;
  logic [DATA_W-1:0] r_rx;

  logic              w_start;
  logic              w_tick;
  logic [EC_W-1:0]   w_edge;
  logic              w_lead;
  logic              w_last;
  logic              w_sample;
  logic              w_shift;
  logic [DATA_W-1:0] w_tx_ord;
  logic [DATA_W-1:0] w_rx_ord;
  logic [NUM_CS-1:0] w_cs_dec;

  // Start is blocked during the done cycle so cs_n stays high at least two cycles
  assign w_start  = (r_state == IDLE) && !r_done && bus.start && !bus.abort;
  assign w_edge   = r_edge_cnt + EC_W'(1);
  assign w_lead   = w_edge[0];
  assign w_last   = (w_edge == EC_W'(EDGES));
  assign w_sample = r_cpha ? !w_lead : w_lead;
  assign w_shift  = r_cpha ? w_lead : (!w_lead && !w_last);

  // Bit-order mapping (first bit on the wire sits in the MSB) and chip-select decode
  always_comb begin
    w_tx_ord = '0;
    w_rx_ord = '0;
    w_cs_dec = '1;
    for (int i = 0; i < DATA_W; i++) begin
      w_tx_ord[i] = bus.lsb_first ? bus.tx[DATA_W-1-i] : bus.tx[i];
      w_rx_ord[i] = r_lsb ? r_rx_sh[DATA_W-1-i] : r_rx_sh[i];
    end
    for (int i = 0; i < NUM_CS; i++) begin
      w_cs_dec[i] = (bus.cs_sel != CS_W'(i));
    end
  end

  spi_half_tick #(.DIV_W(DIV_W)) u_half_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_start),
    .i_en     (r_state != IDLE),
    .i_div    (bus.div),
    .o_tick_c (w_tick)
  );

  // Transfer FSM with all pin and status outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_edge_cnt <= '0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cs_n     <= '1;
      r_rx       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sck <= bus.cpol;
          if (w_start) begin
            r_state    <= LEAD;
            r_cpol     <= bus.cpol;
            r_cpha     <= bus.cpha;
            r_lsb      <= bus.lsb_first;
            r_cs_n     <= w_cs_dec;
            r_busy     <= 1'b1;
            r_edge_cnt <= '0;
            if (!bus.cpha) begin
              r_mosi  <= w_tx_ord[DATA_W-1];
              r_tx_sh <= {w_tx_ord[DATA_W-2:0], 1'b0};
            end else begin
              r_tx_sh <= w_tx_ord;
            end
          end
        end
        default: begin
          if (bus.abort) begin
            r_state <= IDLE;
            r_cs_n  <= '1;
            r_busy  <= 1'b0;
            r_sck   <= r_cpol;
          end else if (w_tick) begin
            if (r_state == TRAIL) begin
              r_state <= IDLE;
              r_cs_n  <= '1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_rx    <= w_rx_ord;
            end else begin
              r_sck      <= ~r_sck;
              r_edge_cnt <= w_edge;
              r_state    <= w_last ? TRAIL : XFER;
              if (w_sample) begin
                r_rx_sh <= {r_rx_sh[DATA_W-2:0], bus.miso};
              end
              if (w_shift) begin
                r_mosi  <= r_tx_sh[DATA_W-1];
                r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.sck  = r_sck;
  assign bus.mosi = r_mosi;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.cs_n = r_cs_n;
  assign bus.rx   = r_rx;
endmodule

// File: tb/tb_spi_master_cfg.sv
// Randomized and directed bench for spi_master_cfg with a behavioural SPI slave.
module tb_spi_master_cfg;
  import spi_pkg::*;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NUM_CS = 4;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned CS_W   = cs_w(NUM_CS);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic loop_en  = 1'b0;
  logic slv_miso = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_cfg_if #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) bus ();

  spi_master_cfg #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.miso = loop_en ? bus.mosi : slv_miso;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // Word bit carried by the j-th bit on the wire
  function automatic int bitpos(input logic lsb, input int j);
    return lsb ? j : int'(DATA_W) - 1 - j;
  endfunction

  // One transfer with a slave model; optional abort after edge abort_at, spurious start at t0+spur_at
  task automatic do_xfer(input logic cpol, input logic cpha, input logic lsb, input int div,
                         input int cs, input logic [7:0] tx, input logic [7:0] sword,
                         input logic loop, input int abort_at, input int spur_at);
    int t0, k, rise, done_cyc, exp_done, c;
    logic [7:0] cap, prev_rx, exp_rx;
    logic [3:0] exp_cs;
    logic prev_sck, cs_ok, first_mosi, got_done, aborted, saw_done, busy_at_done;
    logic [3:0] cs_at_done;
    exp_cs = ~(4'(1) << cs);
    @(negedge clk);
    bus.cpol = cpol; bus.cpha = cpha; bus.lsb_first = lsb;
    bus.div = DIV_W'(div); bus.cs_sel = CS_W'(cs); bus.tx = tx;
    loop_en = loop;
    slv_miso = sword[bitpos(lsb, 0)];
    @(negedge clk);
    chk_eq("idle_sck", bus.sck, cpol);
    prev_rx = bus.rx;
    bus.start = 1'b1;
    t0 = cyc;
    exp_done = t0 + 1 + (2 * DATA_W + 1) * (div + 1);
    k = 0; rise = 0; cap = '0; cs_ok = 1'b1; got_done = 1'b0; aborted = 1'b0;
    prev_sck = cpol; first_mosi = 1'b0; done_cyc = 0; busy_at_done = 1'b1; cs_at_done = '0;
    c = 0;
    while (c < exp_done - t0 + 8 && !got_done && !aborted) begin
      @(negedge clk);
      c++;
      bus.start = (spur_at != 0 && cyc == t0 + spur_at);
      if (bus.start) bus.tx = ~tx;
      if (cyc == t0 + 1) begin
        chk_eq("lead_busy", bus.busy, 1'b1);
        chk_eq("lead_cs_n", bus.cs_n, exp_cs);
      end
      if (bus.busy && bus.cs_n !== exp_cs) cs_ok = 1'b0;
      if (bus.sck !== prev_sck) begin
        k++;
        if (bus.sck) rise++;
        if (k == 1) first_mosi = bus.mosi;
        if (!cpha) begin
          if (k % 2 == 1) cap[bitpos(lsb, (k - 1) / 2)] = bus.mosi;
          else if (k < 2 * DATA_W) slv_miso = sword[bitpos(lsb, k / 2)];
        end else begin
          if (k % 2 == 1) slv_miso = sword[bitpos(lsb, (k - 1) / 2)];
          else cap[bitpos(lsb, k / 2 - 1)] = bus.mosi;
        end
        prev_sck = bus.sck;
        if (abort_at != 0 && k == abort_at) begin
          bus.abort = 1'b1;
          aborted = 1'b1;
        end
      end
      if (bus.done) begin
        got_done = 1'b1; done_cyc = cyc; busy_at_done = bus.busy; cs_at_done = bus.cs_n;
      end
    end
    bus.start = 1'b0;
    if (aborted) begin
      @(negedge clk);
      bus.abort = 1'b0;
      chk_eq("abort_cs_n", bus.cs_n, 4'hF);
      chk_eq("abort_busy", bus.busy, 1'b0);
      chk_eq("abort_sck", bus.sck, cpol);
      saw_done = bus.done;
      for (int i = 0; i < (2 * DATA_W + 2) * (div + 1) + 4; i++) begin
        @(negedge clk);
        if (bus.done) saw_done = 1'b1;
      end
      chk_eq("abort_no_done", saw_done, 1'b0);
      chk_eq("abort_rx_kept", bus.rx, prev_rx);
    end else begin
      exp_rx = loop ? tx : sword;
      chk_eq("done_seen", got_done, 1'b1);
      chk_eq("done_cycle", done_cyc - t0, exp_done - t0);
      chk_eq("done_busy", busy_at_done, 1'b0);
      chk_eq("done_cs_n", cs_at_done, 4'hF);
      chk_eq("sck_edges", k, 2 * DATA_W);
      chk_eq("sck_rises", rise, DATA_W);
      chk_eq("cs_n_during", cs_ok, 1'b1);
      chk_eq("first_mosi", first_mosi, tx[bitpos(lsb, 0)]);
      chk_eq("slave_got_tx", cap, tx);
      chk_eq("rx_word", bus.rx, exp_rx);
      @(negedge clk);
      chk_eq("done_one_cycle", bus.done, 1'b0);
      chk_eq("no_requeue", bus.busy, 1'b0);
      chk_eq("post_sck_idle", bus.sck, cpol);
    end
  endtask

  // Start held high: two transfers with a two-cycle cs_n gap between them
  task automatic back_to_back();
    int t0, rises[$], dones[$];
    logic prev_busy;
    @(negedge clk);
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsb_first = 1'b0; bus.div = '0;
    bus.cs_sel = '0; bus.tx = 8'h5A; loop_en = 1'b1;
    bus.start = 1'b1;
    t0 = cyc;
    prev_busy = 1'b0;
    for (int c = 0; c < 80 && dones.size() < 2; c++) begin
      @(negedge clk);
      if (bus.busy && !prev_busy) rises.push_back(cyc);
      if (bus.done) dones.push_back(cyc);
      if (rises.size() == 2) bus.start = 1'b0;
      prev_busy = bus.busy;
    end
    bus.start = 1'b0;
    chk_eq("b2b_rises", rises.size(), 2);
    chk_eq("b2b_dones", dones.size(), 2);
    if (rises.size() == 2 && dones.size() == 2) begin
      chk_eq("b2b_lead0", rises[0] - t0, 1);
      chk_eq("b2b_done0", dones[0] - t0, 18);
      chk_eq("b2b_gap", rises[1] - dones[0], 2);
      chk_eq("b2b_done1", dones[1] - t0, 37);
    end
    chk_eq("b2b_rx", bus.rx, 8'h5A);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rtx, rsw;
    logic [1:0] rmode;
    bus.start = 1'b0; bus.abort = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0;
    bus.lsb_first = 1'b0; bus.div = '0; bus.cs_sel = '0; bus.tx = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_sck", bus.sck, 1'b0);
    chk_eq("rst_mosi", bus.mosi, 1'b0);
    chk_eq("rst_cs_n", bus.cs_n, 4'hF);
    chk_eq("rst_busy", bus.busy, 1'b0);
    chk_eq("rst_done", bus.done, 1'b0);
    chk_eq("rst_rx", bus.rx, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // mode 0 loopback, div 0
    do_xfer(MODE0[1], MODE0[0], 1'b0, 0, 0, 8'hA5, 8'h00, 1'b1, 0, 0);
    // mode 3, div 3, cs 2
    do_xfer(MODE3[1], MODE3[0], 1'b0, 3, 2, 8'hC3, 8'h3C, 1'b0, 0, 0);
    // LSB first, mode 1
    do_xfer(MODE1[1], MODE1[0], 1'b1, 0, 1, 8'h01, 8'h80, 1'b0, 0, 0);
    // abort after 5th edge, then a normal transfer
    do_xfer(MODE0[1], MODE0[0], 1'b0, 1, 3, 8'h96, 8'h69, 1'b0, 5, 0);
    do_xfer(MODE2[1], MODE2[0], 1'b0, 1, 3, 8'h96, 8'h69, 1'b0, 0, 0);
    // spurious start mid-transfer
    do_xfer(MODE0[1], MODE0[0], 1'b0, 0, 1, 8'h4B, 8'hD2, 1'b0, 0, 5);
    back_to_back();

    // start and abort together in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk_eq("start_abort_busy", bus.busy, 1'b0);
    chk_eq("start_abort_cs_n", bus.cs_n, 4'hF);

    for (int n = 0; n < 12; n++) begin
      rtx = 8'($urandom);
      rsw = 8'($urandom);
      rmode = 2'($urandom);
      do_xfer(rmode[1], rmode[0], 1'($urandom), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 3)), rtx, rsw, 1'b0, 0, 0);
    end

    // asynchronous reset in the middle of a transfer
    @(negedge clk);
    bus.cpol = 1'b1; bus.cpha = 1'b0; bus.lsb_first = 1'b0; bus.div = DIV_W'(1);
    bus.cs_sel = CS_W'(1); bus.tx = 8'hFF; loop_en = 1'b0; slv_miso = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk_eq("pre_rst_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_eq("async_sck", bus.sck, 1'b0);
    chk_eq("async_mosi", bus.mosi, 1'b0);
    chk_eq("async_cs_n", bus.cs_n, 4'hF);
    chk_eq("async_busy", bus.busy, 1'b0);
    chk_eq("async_done", bus.done, 1'b0);
    chk_eq("async_rx", bus.rx, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    do_xfer(MODE1[1], MODE1[0], 1'b0, 2, 0, 8'h3E, 8'hE3, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
Parametrised, mode-configurable SPI master. Supports all four CPOL/CPHA modes, MSB- or LSB-first order, a runtime SCK divider and multiple chip selects. A start/busy/done handshake lets a local controller issue one DATA_W-bit full-duplex transfer at a time.

Parameters:
DATA_W, 8, bits per transfer (2..32)
NUM_CS, 4, number of chip-select outputs (1..16)
DIV_W, 16, width of the runtime divider input

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a transfer; sampled only in IDLE
abort  input  1  synchronous abort of the current transfer
cpol  input  1  SCK idle level
cpha  input  1  0: sample on leading edge; 1: sample on trailing edge
lsb_first  input  1  1: shift LSB first
div  input  DIV_W  SCK half-period = div+1 clk cycles
cs_sel  input  $clog2(NUM_CS) (min 1)  chip select index
tx  input  DATA_W  transmit word
rx  output  DATA_W  last completed receive word
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle completion pulse
sck  output  1  serial clock
mosi  output  1  serial data out
miso  input  1  serial data in
cs_n  output  NUM_CS  active-low chip selects

Behaviour:
- Reset values (asynchronous): sck=0, mosi=0, cs_n=all 1, busy=0, done=0, rx=0, state IDLE, all counters 0.
- All outputs are registered. MISO is sampled in the clk domain on the cycle sck changes to its sampling edge; no synchroniser.
- States: IDLE, LEAD, XFER, TRAIL.
- IDLE:
  - sck follows cpol, registered each cycle.
  - On start=1 with abort=0 at cycle T0, latch cpol, cpha, lsb_first, div, cs_sel and tx.
- LEAD (entered at T0+1):
  - cs_n[cs_sel]=0 and busy=1.
  - If cpha=0, mosi takes the first bit (tx[DATA_W-1], or tx[0] if lsb_first).
  - Lasts div+1 cycles, then the first SCK edge occurs.
- XFER:
  - 2*DATA_W SCK edges, one every div+1 cycles. Odd edges are leading, even edges are trailing.
  - cpha=0: sample on leading edges; shift out the next bit on trailing edges, except the final trailing edge.
  - cpha=1: drive the next bit on leading edges; sample on trailing edges.
  - After the last edge, sck sits at the latched cpol.
- TRAIL:
  - Lasts div+1 cycles after the last edge.
  - In the final cycle: cs_n returns to all 1, busy=0, done=1 for one cycle, and rx is loaded with the assembled word in bit order per lsb_first.
  - Done cycle = T0+1+(2*DATA_W+1)*(div+1). For DATA_W=8, div=0 this is T0+18.
  - Next state is IDLE. A new start is accepted the cycle after done, so cs_n stays high for at least 2 cycles between transfers.
- start while busy: ignored, no queueing.
- Inputs change mid-transfer: ignored; the latched copies are used.
- abort=1 in LEAD, XFER or TRAIL: next cycle cs_n=all 1, busy=0, sck=latched cpol, state IDLE. No done pulse; rx unchanged.
- start=1 and abort=1 together in IDLE: abort wins and nothing is started.
- cs_sel >= NUM_CS: no cs_n line asserts, but the transfer runs normally and done still pulses.
- div=0: SCK frequency = clk/2. The half-period counter must not wrap for div = 2^DIV_W-1.
- rst_n low mid-transfer: all outputs go to reset values immediately; no done.
- Bit counter width: $clog2(2*DATA_W+1).

Decomposition:
- Shared package spi_pkg holds:
  - state enum (IDLE, LEAD, XFER, TRAIL)
  - SPI mode constants MODE0..MODE3 as {cpol,cpha}
  - function for cs_sel width
- One natural sub-module, spi_half_tick:
  - loadable down-counter producing a one-cycle tick every div+1 cycles while enabled
  - reloaded on LEAD entry

Test Plan:
- Mode 0, div=0, tx=0xA5, miso looped to mosi, start at T0 -> cs_n[0]=0 at T0+1, 8 rising sck edges, done at T0+18, rx=0xA5, busy low at T0+18.
- Mode 3, div=3, cs_sel=2, slave model returns 0x3C -> cs_n=4'b1011 during transfer, sck idles high, done at T0+69, rx=0x3C.
- lsb_first=1, mode 1, tx=0x01, slave returns 0x80 (LSB first) -> first mosi bit 1 on first leading edge, rx=0x80.
- abort asserted after 5th sck edge -> cs_n=4'hF and busy=0 the next cycle, no done pulse, rx keeps previous value, next start works normally.
- start pulsed again at T0+5 while busy, then start held high continuously -> mid-transfer pulse ignored; back-to-back transfers begin with cs_n high for 2 cycles between them.
- rst_n driven low mid-XFER -> sck=0, mosi=0, cs_n=4'hF, busy=0, rx=0 immediately, without waiting for a clk edge.
